modulo_updown_counter: RTL

MODULO_UPDOWN_COUNTER -- requirements
Module: modulo_updown_counter

---
 rtl/modulo_updown_counter.sv | 106 ++++++++++
 1 files changed

// File: rtl/modulo_updown_counter.sv
// Modulo up/down counter with a parallel load, a wrap/saturate bound
// policy, one-cycle carry/borrow pulses on wrap-around and a sticky
// overflow flag that records any bound event (wrap or saturation).
module modulo_updown_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 2 ** WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             count_up,
    input  logic             count_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             sat_mode,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] cnt,
    output logic             carry,
    output logic             borrow,
    output logic             at_max,
    output logic             at_min,
    output logic             ovf
);

    // Top of the count range; when MODULUS == 2**WIDTH this is all ones,
    // so wrapping to zero is ordinary binary roll-over.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] MIN_VAL = '0;

    logic [WIDTH-1:0] cnt_next;
    logic             carry_next;
    logic             borrow_next;
    logic             ovf_next;
    logic             ovf_set;
    logic             step_up;
    logic             step_down;
    logic [WIDTH-1:0] load_clamped;

    // A single direction request is a real step; both or neither means hold.
    assign step_up   = count_up & ~count_down;
    assign step_down = count_down & ~count_up;

    // Out-of-range load values are pulled down to the top of the range so
    // the count can never leave 0..MODULUS-1.
    assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

    // Bound indicators follow the registered count directly.
    assign at_max = (cnt == MAX_VAL);
    assign at_min = (cnt == MIN_VAL);

    // Next-state decode: load beats counting; bound events set the sticky
    // flag, and a set in the same cycle as a clear request wins.
    always_comb begin
        cnt_next    = cnt;
        carry_next  = 1'b0;
        borrow_next = 1'b0;
        ovf_set     = 1'b0;

        if (load) begin
            cnt_next = load_clamped;
        end else if (step_up) begin
            if (cnt == MAX_VAL) begin
                ovf_set = 1'b1;
                if (!sat_mode) begin
                    cnt_next   = MIN_VAL;
                    carry_next = 1'b1;
                end
            end else begin
                cnt_next = cnt + 1'b1;
            end
        end else if (step_down) begin
            if (cnt == MIN_VAL) begin
                ovf_set = 1'b1;
                if (!sat_mode) begin
                    cnt_next    = MAX_VAL;
                    borrow_next = 1'b1;
                end
            end else begin
                cnt_next = cnt - 1'b1;
            end
        end

        if (ovf_set) begin
            ovf_next = 1'b1;
        end else if (clr_ovf) begin
            ovf_next = 1'b0;
        end else begin
            ovf_next = ovf;
        end
    end

    // State register; reset overrides load and counting on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            carry  <= 1'b0;
            borrow <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            cnt    <= cnt_next;
            carry  <= carry_next;
            borrow <= borrow_next;
            ovf    <= ovf_next;
        end
    end

endmodule
